rs: RTL and testbench

// - ALU reservation station: sits between decoder and ROB. Holds issued ALU/branch ops until both operands are ready.
// - Executes one op per cycle and broadcasts the result on the RS CDB port (rs_has_output/rs_rob_id/rs_output).
// - The ROB and LSB consume that broadcast. Branch results are 0/1 in bit 0, which the ROB compares against the prediction.

---
 rtl/rs.sv | 199 +++++++++++++++++++
 tb/tb_rs.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs.sv
// ALU reservation station: buffers issued ALU/branch ops until both operands
// are ready, then executes one per cycle and broadcasts on the RS CDB.
module rs #(
  parameter int unsigned RS_W  = 3,
  parameter int unsigned ROB_W = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_clear,
  output logic             rs_full,
  input  logic             is_ins,
  input  logic [3:0]       ins_op,
  input  logic [ROB_W-1:0] ins_rob_id,
  input  logic             ins_qj_busy,
  input  logic [ROB_W-1:0] ins_qj,
  input  logic [31:0]      ins_vj,
  input  logic             ins_qk_busy,
  input  logic [ROB_W-1:0] ins_qk,
  input  logic [31:0]      ins_vk,
  input  logic             lsb_has_output,
  input  logic [ROB_W-1:0] lsb_rob_id,
  input  logic [31:0]      lsb_output,
  output logic             rs_has_output,
  output logic [ROB_W-1:0] rs_rob_id,
  output logic [31:0]      rs_output
);

  localparam int unsigned RS_N  = 1 << RS_W;
  localparam int unsigned CNT_W = RS_W + 1;

  typedef struct packed {
    logic             busy;
    logic [ROB_W-1:0] tag;
    logic [31:0]      val;
  } operand_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [ROB_W-1:0] rob_id;
    operand_t         j;
    operand_t         k;
  } entry_t;

  logic [RS_N-1:0]  busy_q, busy_d;
  entry_t           ent_q [RS_N];
  entry_t           ent_d [RS_N];
  entry_t           new_ent;
  logic             cdb_vld_q, cdb_vld_d;
  logic [ROB_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [31:0]      cdb_val_q, cdb_val_d;
  logic             full_q, full_d;
  logic             disp_vld, free_vld;
  logic [RS_W-1:0]  disp_idx, free_idx;
  logic [CNT_W-1:0] free_cnt;

  // Capture a broadcast value for a waiting operand; LSB wins over RS.
  function automatic operand_t snoop(
    input operand_t         o,
    input logic             l_vld,
    input logic [ROB_W-1:0] l_tag,
    input logic [31:0]      l_val,
    input logic             r_vld,
    input logic [ROB_W-1:0] r_tag,
    input logic [31:0]      r_val
  );
    operand_t res;
    res = o;
    if (o.busy) begin
      if (l_vld && (l_tag == o.tag)) begin
        res.busy = 1'b0;
        res.val  = l_val;
      end else if (r_vld && (r_tag == o.tag)) begin
        res.busy = 1'b0;
        res.val  = r_val;
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] alu(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [4:0]  sh;
    logic [31:0] res;
    sh = b[4:0];
    case (op)
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd2:    res = a << sh;
      4'd3:    res = {31'b0, $signed(a) < $signed(b)};
      4'd4:    res = {31'b0, a < b};
      4'd5:    res = a ^ b;
      4'd6:    res = a >> sh;
      4'd7:    res = 32'($signed(a) >>> sh);
      4'd8:    res = a | b;
      4'd9:    res = a & b;
      4'd10:   res = {31'b0, a == b};
      4'd11:   res = {31'b0, a != b};
      4'd12:   res = {31'b0, $signed(a) < $signed(b)};
      4'd13:   res = {31'b0, $signed(a) >= $signed(b)};
      4'd14:   res = {31'b0, a < b};
      4'd15:   res = {31'b0, a >= b};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Wakeup, dispatch selection, issue and occupancy for the next state.
  always_comb begin
    busy_d    = busy_q;
    ent_d     = ent_q;
    cdb_vld_d = 1'b0;
    cdb_tag_d = cdb_tag_q;
    cdb_val_d = cdb_val_q;
    disp_vld  = 1'b0;
    disp_idx  = '0;
    free_vld  = 1'b0;
    free_idx  = '0;
    free_cnt  = '0;
    new_ent   = '0;

    for (int i = 0; i < int'(RS_N); i++) begin
      if (busy_q[i]) begin
        ent_d[i].j = snoop(ent_q[i].j, lsb_has_output, lsb_rob_id, lsb_output,
                           cdb_vld_q, cdb_tag_q, cdb_val_q);
        ent_d[i].k = snoop(ent_q[i].k, lsb_has_output, lsb_rob_id, lsb_output,
                           cdb_vld_q, cdb_tag_q, cdb_val_q);
        if (!disp_vld && !ent_q[i].j.busy && !ent_q[i].k.busy) begin
          disp_vld = 1'b1;
          disp_idx = RS_W'(i);
        end
      end else if (!free_vld) begin
        free_vld = 1'b1;
        free_idx = RS_W'(i);
      end
    end

    if (disp_vld) begin
      busy_d[disp_idx] = 1'b0;
      cdb_vld_d        = 1'b1;
      cdb_tag_d        = ent_q[disp_idx].rob_id;
      cdb_val_d        = alu(ent_q[disp_idx].op, ent_q[disp_idx].j.val, ent_q[disp_idx].k.val);
    end

    // A freed dispatch slot only becomes reusable next cycle (free_idx uses busy_q).
    if (is_ins && free_vld) begin
      new_ent.op     = ins_op;
      new_ent.rob_id = ins_rob_id;
      new_ent.j      = snoop(operand_t'({ins_qj_busy, ins_qj, ins_vj}), lsb_has_output,
                             lsb_rob_id, lsb_output, cdb_vld_q, cdb_tag_q, cdb_val_q);
      new_ent.k      = snoop(operand_t'({ins_qk_busy, ins_qk, ins_vk}), lsb_has_output,
                             lsb_rob_id, lsb_output, cdb_vld_q, cdb_tag_q, cdb_val_q);
      ent_d[free_idx]  = new_ent;
      busy_d[free_idx] = 1'b1;
    end

    if (rob_clear) begin
      busy_d    = '0;
      cdb_vld_d = 1'b0;
    end

    for (int i = 0; i < int'(RS_N); i++) begin
      free_cnt = free_cnt + CNT_W'(!busy_d[i]);
    end
    full_d = (free_cnt <= CNT_W'(1));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q    <= '0;
      cdb_vld_q <= 1'b0;
      cdb_tag_q <= '0;
      cdb_val_q <= '0;
      full_q    <= 1'b0;
    end else if (rdy_in) begin
      busy_q    <= busy_d;
      cdb_vld_q <= cdb_vld_d;
      cdb_tag_q <= cdb_tag_d;
      cdb_val_q <= cdb_val_d;
      full_q    <= full_d;
    end
  end

  // Payload storage is qualified by busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      ent_q <= ent_d;
    end
  end

  assign rs_full       = full_q;
  assign rs_has_output = cdb_vld_q;
  assign rs_rob_id     = cdb_tag_q;
  assign rs_output     = cdb_val_q;

endmodule

// File: tb/tb_rs.sv
// Randomized and directed bench for rs, checked every cycle against a
// slot-level behavioural model of the station.
module tb_rs;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, rob_clear, rs_full;
  logic        is_ins;
  logic [3:0]  ins_op;
  logic [2:0]  ins_rob_id, ins_qj, ins_qk;
  logic        ins_qj_busy, ins_qk_busy;
  logic [31:0] ins_vj, ins_vk;
  logic        lsb_has_output;
  logic [2:0]  lsb_rob_id;
  logic [31:0] lsb_output;
  logic        rs_has_output;
  logic [2:0]  rs_rob_id;
  logic [31:0] rs_output;

  int checks = 0;
  int errors = 0;

  // Model state: one record per slot, operand "waiting" flag + tag + value.
  logic        m_busy [8];
  logic [3:0]  m_op   [8];
  logic [2:0]  m_id   [8];
  logic        m_jw   [8];
  logic [2:0]  m_jt   [8];
  logic [31:0] m_jv   [8];
  logic        m_kw   [8];
  logic [2:0]  m_kt   [8];
  logic [31:0] m_kv   [8];
  logic        m_has, m_full;
  logic [2:0]  m_rid;
  logic [31:0] m_out;

  always #5 clk = ~clk;

  rs dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .rs_full(rs_full), .is_ins(is_ins), .ins_op(ins_op), .ins_rob_id(ins_rob_id),
    .ins_qj_busy(ins_qj_busy), .ins_qj(ins_qj), .ins_vj(ins_vj),
    .ins_qk_busy(ins_qk_busy), .ins_qk(ins_qk), .ins_vk(ins_vk),
    .lsb_has_output(lsb_has_output), .lsb_rob_id(lsb_rob_id), .lsb_output(lsb_output),
    .rs_has_output(rs_has_output), .rs_rob_id(rs_rob_id), .rs_output(rs_output)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb;
    int unsigned sh;
    logic [63:0] ext;
    logic [31:0] r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sh  = b & 32'd31;
    ext = {{32{a[31]}}, a} >> sh;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a + (~b) + 32'd1;
      4'd2:  r = a << sh;
      4'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  r = (a < b) ? 32'd1 : 32'd0;
      4'd5:  r = a ^ b;
      4'd6:  r = a >> sh;
      4'd7:  r = ext[31:0];
      4'd8:  r = a | b;
      4'd9:  r = a & b;
      4'd10: r = (a == b) ? 32'd1 : 32'd0;
      4'd11: r = (a != b) ? 32'd1 : 32'd0;
      4'd12: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd13: r = (sa >= sb) ? 32'd1 : 32'd0;
      4'd14: r = (a < b) ? 32'd1 : 32'd0;
      default: r = (a >= b) ? 32'd1 : 32'd0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand resolution against this cycle's broadcasts (LSB first).
  task automatic snoop(input logic w, input logic [2:0] t, input logic [31:0] v,
                       input logic rv, input logic [2:0] rt, input logic [31:0] rval,
                       output logic nw, output logic [31:0] nv);
    nw = w;
    nv = v;
    if (w && lsb_has_output && lsb_rob_id == t) begin
      nw = 1'b0; nv = lsb_output;
    end else if (w && rv && rt == t) begin
      nw = 1'b0; nv = rval;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
    m_has = 1'b0; m_rid = 3'd0; m_out = 32'd0; m_full = 1'b0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_next();
    logic        o_busy [8];
    logic        o_jw [8];
    logic        o_kw [8];
    logic [31:0] o_jv [8];
    logic [31:0] o_kv [8];
    logic        c_v;
    logic [2:0]  c_t;
    logic [31:0] c_val;
    int          d, f, nfree;
    o_busy = m_busy; o_jw = m_jw; o_kw = m_kw; o_jv = m_jv; o_kv = m_kv;
    c_v = m_has; c_t = m_rid; c_val = m_out;
    d = -1; f = -1; nfree = 0;
    if (!rdy_in) return;
    if (rob_clear) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      m_has = 1'b0; m_full = 1'b0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      if (d < 0 && o_busy[i] && !o_jw[i] && !o_kw[i]) d = i;
      if (f < 0 && !o_busy[i]) f = i;
      if (o_busy[i]) begin
        snoop(o_jw[i], m_jt[i], o_jv[i], c_v, c_t, c_val, m_jw[i], m_jv[i]);
        snoop(o_kw[i], m_kt[i], o_kv[i], c_v, c_t, c_val, m_kw[i], m_kv[i]);
      end
    end
    if (d >= 0) begin
      m_has = 1'b1; m_rid = m_id[d]; m_out = ref_alu(m_op[d], o_jv[d], o_kv[d]);
      m_busy[d] = 1'b0;
    end else begin
      m_has = 1'b0;
    end
    if (is_ins && f >= 0) begin
      m_busy[f] = 1'b1; m_op[f] = ins_op; m_id[f] = ins_rob_id;
      m_jt[f] = ins_qj; m_kt[f] = ins_qk;
      snoop(ins_qj_busy, ins_qj, ins_vj, c_v, c_t, c_val, m_jw[f], m_jv[f]);
      snoop(ins_qk_busy, ins_qk, ins_vk, c_v, c_t, c_val, m_kw[f], m_kv[f]);
    end
    for (int i = 0; i < 8; i++) if (!m_busy[i]) nfree++;
    m_full = (nfree <= 1);
  endtask

  task automatic compare();
    chk("has_output", 32'(rs_has_output), 32'(m_has));
    if (m_has) begin
      chk("rob_id", 32'(rs_rob_id), 32'(m_rid));
      chk("output", rs_output, m_out);
    end
    chk("full", 32'(rs_full), 32'(m_full));
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic clr();
    is_ins = 1'b0; ins_op = 4'd0; ins_rob_id = 3'd0;
    ins_qj_busy = 1'b0; ins_qj = 3'd0; ins_vj = 32'd0;
    ins_qk_busy = 1'b0; ins_qk = 3'd0; ins_vk = 32'd0;
    lsb_has_output = 1'b0; lsb_rob_id = 3'd0; lsb_output = 32'd0;
    rob_clear = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rid,
                       input logic jb, input logic [2:0] qj, input logic [31:0] vj,
                       input logic kb, input logic [2:0] qk, input logic [31:0] vk);
    is_ins = 1'b1; ins_op = op; ins_rob_id = rid;
    ins_qj_busy = jb; ins_qj = qj; ins_vj = vj;
    ins_qk_busy = kb; ins_qk = qk; ins_vk = vk;
  endtask

  task automatic lsb(input logic [2:0] t, input logic [31:0] v);
    lsb_has_output = 1'b1; lsb_rob_id = t; lsb_output = v;
  endtask

  function automatic logic [31:0] rnd_val();
    return ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
  endfunction

  task automatic single(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    issue(op, 3'd1, 1'b0, 3'd0, a, 1'b0, 3'd0, b);
    step();
    clr();
    step();
    chk({name, "_has"}, 32'(rs_has_output), 32'd1);
    chk(name, rs_output, exp);
  endtask

  initial begin
    clr();
    rst_in = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_has", 32'(rs_has_output), 32'd0);
    chk("rst_id", 32'(rs_rob_id), 32'd0);
    chk("rst_out", rs_output, 32'd0);
    chk("rst_full", 32'(rs_full), 32'd0);
    rst_in = 1'b0;

    // ADD with both operands ready: visible two edges after issue.
    issue(4'd0, 3'd2, 1'b0, 3'd0, 32'd5, 1'b0, 3'd0, 32'd7);
    step();
    clr();
    step();
    chk("add_has", 32'(rs_has_output), 32'd1);
    chk("add_id", 32'(rs_rob_id), 32'd2);
    chk("add_out", rs_output, 32'd12);

    // SUB woken by LSB broadcast one cycle after issue.
    issue(4'd1, 3'd3, 1'b1, 3'd4, 32'd0, 1'b0, 3'd0, 32'd1);
    step();
    clr();
    lsb(3'd4, 32'd10);
    step();
    clr();
    step();
    chk("sub_has", 32'(rs_has_output), 32'd1);
    chk("sub_id", 32'(rs_rob_id), 32'd3);
    chk("sub_out", rs_output, 32'd9);

    single("blt", 4'd12, 32'hFFFF_FFFF, 32'd1, 32'd1);
    single("bltu", 4'd14, 32'hFFFF_FFFF, 32'd1, 32'd0);
    single("sra", 4'd7, 32'h8000_0000, 32'd33, 32'hC000_0000);
    step();
    step();

    // Seven entries waiting on tag 5, then drained in index order.
    for (int i = 0; i < 7; i++) begin
      issue(4'd0, 3'(i), 1'b1, 3'd5, 32'd0, 1'b0, 3'd0, 32'(i));
      step();
      if (i == 5) chk("full_at_6", 32'(rs_full), 32'd0);
    end
    clr();
    chk("full_at_7", 32'(rs_full), 32'd1);
    lsb(3'd5, 32'd100);
    step();
    clr();
    for (int i = 0; i < 7; i++) begin
      step();
      chk("drain_has", 32'(rs_has_output), 32'd1);
      chk("drain_id", 32'(rs_rob_id), 32'(i));
      chk("drain_out", rs_output, 32'(100 + i));
    end
    step();

    // Flush with four pending entries and one op about to dispatch.
    for (int i = 0; i < 4; i++) begin
      issue(4'd0, 3'(i), 1'b1, 3'd6, 32'd0, 1'b0, 3'd0, 32'd1);
      step();
    end
    issue(4'd0, 3'd7, 1'b0, 3'd0, 32'd1, 1'b0, 3'd0, 32'd1);
    step();
    clr();
    rob_clear = 1'b1;
    step();
    clr();
    chk("clr_has", 32'(rs_has_output), 32'd0);
    chk("clr_full", 32'(rs_full), 32'd0);
    lsb(3'd6, 32'd1);
    step();
    clr();
    repeat (4) begin
      step();
      chk("clr_quiet", 32'(rs_has_output), 32'd0);
    end

    // Randomized traffic including freezes and flushes.
    repeat (2000) begin
      clr();
      rdy_in    = ($urandom_range(0, 9) != 0);
      rob_clear = ($urandom_range(0, 39) == 0);
      if (!m_full && $urandom_range(0, 1) == 1)
        issue(4'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), rnd_val(),
              1'($urandom), 3'($urandom), rnd_val());
      if ($urandom_range(0, 2) == 0) begin
        lsb(3'($urandom), rnd_val());
        if (m_has && lsb_rob_id == m_rid) lsb_rob_id = lsb_rob_id + 3'd1;
      end
      step();
    end

    // Asynchronous reset with three busy entries and an output present.
    clr();
    rob_clear = 1'b1;
    step();
    clr();
    for (int i = 0; i < 3; i++) begin
      issue(4'd0, 3'(i), 1'b1, 3'd2, 32'd0, 1'b0, 3'd0, 32'd1);
      step();
    end
    issue(4'd0, 3'd4, 1'b0, 3'd0, 32'd3, 1'b0, 3'd0, 32'd4);
    step();
    clr();
    step();
    chk("pre_rst_has", 32'(rs_has_output), 32'd1);
    chk("pre_rst_out", rs_output, 32'd7);
    rst_in = 1'b1;
    #1;
    chk("arst_has", 32'(rs_has_output), 32'd0);
    chk("arst_out", rs_output, 32'd0);
    chk("arst_full", 32'(rs_full), 32'd0);
    model_reset();
    #3;
    rst_in = 1'b0;
    lsb(3'd2, 32'd9);
    step();
    clr();
    repeat (3) begin
      step();
      chk("post_rst_quiet", 32'(rs_has_output), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
